// File: rtl/seq_divider.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seq_divider : unsigned restoring shift-subtract divider, one bit per clock  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int            CW        = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q,     state_d;
    logic [N-1:0]  shift_q,     shift_d;
    logic [N-1:0]  divisor_q,   divisor_d;
    logic [N:0]    prem_q,      prem_d;
    logic [CW-1:0] count_q,     count_d;
    logic [N-1:0]  quotient_q,  quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q,       dbz_d;

    logic [N:0]    shifted;
    logic [N:0]    trial;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        divisor_d   = divisor_q;
        prem_d      = prem_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        shifted = {prem_q[N-1:0], shift_q[N-1]};
        trial   = shifted - {1'b0, divisor_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        shift_d   = dividend;
                        divisor_d = divisor;
                        prem_d    = '0;
                        count_d   = '0;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Dividend bits leave at the top while quotient bits enter at the bottom.
                if (!trial[N]) begin
                    prem_d  = trial;
                    shift_d = {shift_q[N-2:0], 1'b1};
                end else begin
                    prem_d  = shifted;
                    shift_d = {shift_q[N-2:0], 1'b0};
                end
                count_d = count_q + CW'(1);
                if (count_q == LAST_ITER) begin
                    quotient_d  = shift_d;
                    remainder_d = prem_d[N-1:0];
                    dbz_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            divisor_q   <= '0;
            prem_q      <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            divisor_q   <= divisor_d;
            prem_q      <= prem_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
